// File: rtl/scudsp_dma_ctrl_pkg.sv
// Shared types and helpers for the SCU DSP DMA sequencer.
// Holds the sequencer state enum, the latched command record and the
// ADDI address-increment lookup.
package scudsp_dma_ctrl_pkg;

    // Sequencer states. IDLE waits for a command, BRD/RWR move one word
    // D0->RAM, RRD/BWR move one word RAM->D0, DONE performs write-back.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BRD  = 3'd1,
        RWR  = 3'd2,
        RRD  = 3'd3,
        BWR  = 3'd4,
        DONE = 3'd5
    } dma_state_t;

    // Command fields captured on START so the inputs may change afterwards.
    typedef struct packed {
        logic       dir;   // 0: D0->RAM, 1: RAM->D0
        logic [3:0] ramw;  // one-hot data RAM destination
        logic       prgw;  // program RAM destination (wins over ramw)
        logic [1:0] rams;  // data RAM source bank
        logic [2:0] addi;  // address increment code
        logic       hold;  // suppress RA0/WA0 write-back
    } dma_cmd_t;

    // Widest byte increment produced by the ADDI lookup (64 words = 256 bytes).
    localparam int INC_W = 9;

    // ADDI code to byte increment: 0,1,2,4,8,16,32,64 words, 4 bytes each.
    function automatic logic [INC_W-1:0] dma_addr_add(input logic [2:0] addi);
        logic [INC_W-1:0] inc;
        case (addi)
            3'd0:    inc = 9'd0;
            3'd1:    inc = 9'd4;
            3'd2:    inc = 9'd8;
            3'd3:    inc = 9'd16;
            3'd4:    inc = 9'd32;
            3'd5:    inc = 9'd64;
            3'd6:    inc = 9'd128;
            default: inc = 9'd256;
        endcase
        return inc;
    endfunction

    // Two-bit bank number to one-hot strobe vector.
    function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[bank] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/scudsp_dma_ctrl_if.sv
// External D0 bus seen by the SCU DSP DMA sequencer.
//
// Handshake: the master raises BUS_REQ and holds BUS_REQ, BUS_WE, BUS_ADDR
// and BUS_DO stable until it samples BUS_ACK=1 on a rising clock edge; that
// edge completes the cycle. For reads BUS_DI is valid in the ACK cycle. The
// slave pulses BUS_ACK for exactly one cycle per request, and the master
// always drops BUS_REQ for at least one cycle between bus cycles.
interface scudsp_dma_ctrl_if #(
    parameter int ADDR_W = 25
);
    logic              BUS_REQ;
    logic              BUS_WE;
    logic [ADDR_W+1:0] BUS_ADDR;
    logic [31:0]       BUS_DO;
    logic [31:0]       BUS_DI;
    logic              BUS_ACK;

    modport master (
        output BUS_REQ,
        output BUS_WE,
        output BUS_ADDR,
        output BUS_DO,
        input  BUS_DI,
        input  BUS_ACK
    );

    modport slave (
        input  BUS_REQ,
        input  BUS_WE,
        input  BUS_ADDR,
        input  BUS_DO,
        output BUS_DI,
        output BUS_ACK
    );
endinterface

// File: rtl/scudsp_dma_ctrl.sv
// SCU DSP DMA sequencer.
// Runs a decoded DMA command: moves COUNT words between the D0 bus and the
// DSP data RAM banks or program RAM, pulses CTx increments, writes RA0/WA0
// back and holds the T0 busy flag. STATE_DBG exposes the sequencer state.
// Optional build macro SCUDSP_DMA_TIMEOUT_EN adds a bus watchdog and the
// sticky TMO_ERR output.
module scudsp_dma_ctrl
    import scudsp_dma_ctrl_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              DIR,
    input  logic [3:0]        RAMW,
    input  logic              PRGW,
    input  logic [1:0]        RAMS,
    input  logic [2:0]        ADDI,
    input  logic              HOLD,
    input  logic [CNT_W-1:0]  COUNT,
    input  logic [ADDR_W-1:0] RA0,
    input  logic [ADDR_W-1:0] WA0,
    scudsp_dma_ctrl_if.master bus,
    output logic [1:0]        RAM_SEL,
    output logic              RAM_RD,
    input  logic [31:0]       RAM_DI,
    output logic [3:0]        RAM_WE,
    output logic [31:0]       RAM_DO,
    output logic [3:0]        CT_INC,
    output logic              PRG_WE,
    output logic [7:0]        PRG_ADDR,
    output logic [ADDR_W-1:0] RA0_OUT,
    output logic              RA0_WE,
    output logic [ADDR_W-1:0] WA0_OUT,
    output logic              WA0_WE,
    output logic              BUSY,
`ifdef SCUDSP_DMA_TIMEOUT_EN
    output logic              TMO_ERR,
`endif
    output dma_state_t        STATE_DBG
);

    localparam int BA_W = ADDR_W + 2;

    dma_state_t       state;
    dma_state_t       state_nxt;
    dma_cmd_t         cmd;
    logic [BA_W-1:0]  addr;
    logic [BA_W-1:0]  addr_next;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       prg_addr;
    logic [31:0]      ram_do_q;
    logic [31:0]      bus_do_q;
    logic             bwr_first;
    logic             last_word;

    // Watchdog abort strobe and the "this transfer was aborted" marker.
    logic             tmo_hit;
    logic             aborted;

    logic             req_c;
    logic             we_c;
    logic [1:0]       ram_sel_c;
    logic             ram_rd_c;
    logic [3:0]       ram_we_c;
    logic [3:0]       ct_inc_c;
    logic             prg_we_c;
    logic             ra0_we_c;
    logic             wa0_we_c;

    assign addr_next = addr + BA_W'(dma_addr_add(cmd.addi));
    assign last_word = (cnt == CNT_W'(1));

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch, address/count datapath and data capture registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd       <= '0;
            addr      <= '0;
            cnt       <= '0;
            prg_addr  <= '0;
            ram_do_q  <= '0;
            bus_do_q  <= '0;
            bwr_first <= 1'b0;
        end else begin
            bwr_first <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        cmd <= '{dir: DIR, ramw: RAMW, prgw: PRGW,
                                 rams: RAMS, addi: ADDI, hold: HOLD};
                        addr     <= DIR ? {WA0, 2'b00} : {RA0, 2'b00};
                        cnt      <= COUNT;
                        prg_addr <= '0;
                    end
                end
                BRD: begin
                    if (bus.BUS_ACK) begin
                        ram_do_q <= bus.BUS_DI;
                    end
                end
                RWR: begin
                    addr <= addr_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cmd.prgw) begin
                        prg_addr <= prg_addr + 8'd1;
                    end
                end
                RRD: begin
                    // RAM_DI becomes valid in the first BWR cycle.
                    bwr_first <= 1'b1;
                end
                BWR: begin
                    if (bwr_first) begin
                        bus_do_q <= RAM_DI;
                    end
                    if (bus.BUS_ACK) begin
                        addr <= addr_next;
                        cnt  <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SCUDSP_DMA_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       tmo_err_q;

    assign tmo_hit = ((state == BRD) || (state == BWR)) && !bus.BUS_ACK
                     && (wd_cnt == 8'hFF);

    // Watchdog: counts unacknowledged bus cycles, aborts at 255, latches TMO_ERR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_cnt    <= '0;
            tmo_err_q <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            if (((state == BRD) || (state == BWR)) && !bus.BUS_ACK) begin
                wd_cnt <= wd_cnt + 8'd1;
            end else begin
                wd_cnt <= '0;
            end
            if (tmo_hit) begin
                tmo_err_q <= 1'b1;
                aborted   <= 1'b1;
            end else if (state == IDLE) begin
                aborted <= 1'b0;
            end
        end
    end

    assign TMO_ERR = tmo_err_q;
`else
    assign tmo_hit = 1'b0;
    assign aborted = 1'b0;
`endif

    // Next-state and strobe decode.
    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        we_c      = 1'b0;
        ram_sel_c = 2'b00;
        ram_rd_c  = 1'b0;
        ram_we_c  = 4'b0000;
        ct_inc_c  = 4'b0000;
        prg_we_c  = 1'b0;
        ra0_we_c  = 1'b0;
        wa0_we_c  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = DIR ? RRD : BRD;
                end
            end
            BRD: begin
                req_c = 1'b1;
                if (tmo_hit) begin
                    state_nxt = DONE;
                end else if (bus.BUS_ACK) begin
                    state_nxt = RWR;
                end
            end
            RWR: begin
                if (cmd.prgw) begin
                    prg_we_c = 1'b1;
                end else begin
                    ram_we_c = cmd.ramw;
                    ct_inc_c = cmd.ramw;
                end
                state_nxt = last_word ? DONE : BRD;
            end
            RRD: begin
                ram_rd_c  = 1'b1;
                ram_sel_c = cmd.rams;
                ct_inc_c  = bank_onehot(cmd.rams);
                state_nxt = BWR;
            end
            BWR: begin
                req_c = 1'b1;
                we_c  = 1'b1;
                if (tmo_hit) begin
                    state_nxt = DONE;
                end else if (bus.BUS_ACK) begin
                    state_nxt = last_word ? DONE : RRD;
                end
            end
            DONE: begin
                if (!cmd.hold && !aborted) begin
                    if (cmd.dir) begin
                        wa0_we_c = 1'b1;
                    end else begin
                        ra0_we_c = 1'b1;
                    end
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.BUS_REQ  = req_c;
    assign bus.BUS_WE   = we_c;
    assign bus.BUS_ADDR = addr;
    // In the first BWR cycle the RAM output is forwarded directly, later
    // cycles replay the captured copy so BUS_DO stays stable until ACK.
    assign bus.BUS_DO   = bwr_first ? RAM_DI : bus_do_q;

    assign RAM_SEL   = ram_sel_c;
    assign RAM_RD    = ram_rd_c;
    assign RAM_WE    = ram_we_c;
    assign RAM_DO    = ram_do_q;
    assign CT_INC    = ct_inc_c;
    assign PRG_WE    = prg_we_c;
    assign PRG_ADDR  = prg_addr;
    assign RA0_OUT   = addr[BA_W-1:2];
    assign RA0_WE    = ra0_we_c;
    assign WA0_OUT   = addr[BA_W-1:2];
    assign WA0_WE    = wa0_we_c;
    assign BUSY      = (state != IDLE);
    assign STATE_DBG = state;

endmodule

// File: doc/scudsp_dma_ctrl.md
Name: scudsp_dma_ctrl

Overview:
Sequencer for SCU DSP DMA instructions. It moves words between the external D0 bus and the DSP data RAMs (banks 0-3) or the program RAM.
- Accepts an already-decoded DMA command and runs the transfer loop.
- Drives bus and RAM strobes, pulses the CTx increments, and writes RA0/WA0 back.
- Holds the T0 busy flag seen by DSP condition logic.
- Sits beside the DSP execute stage in the SCU.

Parameters:
ADDR_W, 25, D0 word-address width (RA0/WA0); bus byte address is ADDR_W+2 bits
CNT_W, 8, transfer count width; count 0 means 2^CNT_W words

Ports:
CLK  in  1  system clock
RST  in  1  reset
START  in  1  one-cycle pulse: execute decoded DMA command
DIR  in  1  0: D0->RAM, 1: RAM->D0
RAMW  in  4  one-hot data RAM destination (D0->RAM)
PRGW  in  1  program RAM destination (D0->RAM)
RAMS  in  2  data RAM source bank (RAM->D0)
ADDI  in  3  address increment code
HOLD  in  1  1: do not write back RA0/WA0
COUNT  in  CNT_W  resolved transfer count
RA0  in  ADDR_W  read start word address
WA0  in  ADDR_W  write start word address
BUS_REQ  out  1  bus cycle request
BUS_WE  out  1  1: write cycle
BUS_ADDR  out  ADDR_W+2  byte address
BUS_DO  out  32  write data
BUS_DI  in  32  read data, valid with BUS_ACK
BUS_ACK  in  1  bus cycle complete
RAM_SEL  out  2  source bank select for RAM_DI
RAM_RD  out  1  read strobe; RAM_DI valid next cycle
RAM_DI  in  32  data RAM read data
RAM_WE  out  4  one-hot data RAM write strobe
RAM_DO  out  32  RAM/PRG write data
CT_INC  out  4  one-hot CTx increment pulse
PRG_WE  out  1  program RAM write strobe
PRG_ADDR  out  8  program RAM address
RA0_OUT  out  ADDR_W  updated RA0
RA0_WE  out  1  RA0 write-back pulse
WA0_OUT  out  ADDR_W  updated WA0
WA0_WE  out  1  WA0 write-back pulse
BUSY  out  1  T0 flag

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: state IDLE; every output 0, including BUSY, strobes, addresses and data.
- Reset mid-transfer aborts the transfer. BUS_REQ is 0 the cycle after the reset edge; no write-back is performed.
- IDLE:
  - START=1 latches all command inputs.
  - Byte address loads as {RA0,2'b00} for DIR=0, {WA0,2'b00} for DIR=1.
  - Word counter loads COUNT; PRG_ADDR loads 0.
  - BUSY goes 1 the next cycle.
  - Next state: BRD for DIR=0, RRD for DIR=1.
- START while BUSY=1 is ignored.
- BRD: BUS_REQ=1, BUS_WE=0 and BUS_ADDR are held until BUS_ACK. On ACK, BUS_DI is captured into RAM_DO and the next state is RWR.
- RWR (one cycle):
  - Asserts the one RAM_WE bit plus the matching CT_INC bit, or PRG_WE with PRG_ADDR++.
  - Address advances by the increment; counter decrements.
  - Next state is DONE when counter reaches 1, else BRD.
- RRD: RAM_RD=1 with RAM_SEL=RAMS, and CT_INC[RAMS] pulses. Next state is BWR.
- BWR: BUS_DO is RAM_DI captured on BWR entry. BUS_REQ=1 and BUS_WE=1 are held until ACK. On ACK, address and counter update; next state is DONE or RRD.
- Address increment, in bytes: ADDI 0..7 maps to 0, 1, 2, 4, 8, 16, 32, 64 (times 4 for word stride). Address wraps modulo 2^(ADDR_W+2).
- DONE (one cycle):
  - If HOLD=0: pulse RA0_WE (DIR=0) or WA0_WE (DIR=1), with the final byte address >>2 on the OUT port.
  - BUSY clears the following cycle. Next state is IDLE.
- Latency: BUSY is 1 from the cycle after START through the DONE cycle inclusive.
- COUNT=0 performs 2^CNT_W transfers.
- PRG_ADDR wraps 255->0.

Optional Feature:
SCUDSP_DMA_TIMEOUT_EN
- Defined: adds output TMO_ERR (1 bit, reset 0).
  - An 8-bit watchdog counts cycles in BRD/BWR without BUS_ACK.
  - At 255 the transfer aborts to DONE without write-back, and TMO_ERR sets sticky until RST.
- Undefined: no port, no watchdog; BUS_REQ is held indefinitely.

Decomposition:
- SCUDSP_PKG gains the state enum type (IDLE, BRD, RWR, RRD, BWR, DONE) and a latched-command struct (DIR, RAMW, PRGW, RAMS, ADDI, HOLD).
- The existing DMAAddrAdd function in SCUDSP_PKG provides the increment lookup.
- Single module; no sub-module.

Test Plan:
- D0->RAM0: RA0=0x100, COUNT=3, ADDI=1, HOLD=0, ACK after 2 cycles -> BUS_ADDR 0x400, 0x404, 0x408; RAM_WE=0001 three times; CT_INC[0] three pulses; RA0_OUT=0x103 with RA0_WE pulse; BUSY low afterwards.
- RAM2->D0: WA0=0x20, COUNT=2, ADDI=0, RAM_DI=0xA5A5_0001 then 0xA5A5_0002 -> two BUS_WE cycles both at 0x80 with that data; CT_INC[2] x2; WA0_WE=1, WA0_OUT=0x20.
- PRG load: PRGW=1, COUNT=4, HOLD=1 -> PRG_WE at PRG_ADDR 0, 1, 2, 3; RA0_WE never pulses.
- START pulsed during busy transfer -> ignored; transfer completes with original count.
- RST asserted mid-BRD -> BUS_REQ=0 and BUSY=0 next cycle; no RAM_WE; subsequent START runs normally.
- TIMEOUT_EN: BUS_ACK held 0 -> abort after 255 cycles; TMO_ERR=1; no RA0_WE.
